// File: rtl/data_memory.sv
// Word-organised data memory with byte/halfword/word loads and stores.
// After reset a sweep zeroes every word before stores are accepted.
//
// state | meaning
// CLEAR | zeroing word[clr_idx_q] each edge; loads read 0, stores dropped
// RUN   | normal operation; Ready=1
module data_memory #(
    parameter int DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    output logic [31:0] DataRd,
    output logic        Ready,
    output logic        MisalignErr
);

    localparam int AW = $clog2(DEPTH_WORDS);

    localparam logic [2:0] CTRL_B  = 3'b000;
    localparam logic [2:0] CTRL_H  = 3'b001;
    localparam logic [2:0] CTRL_W  = 3'b010;
    localparam logic [2:0] CTRL_BU = 3'b100;
    localparam logic [2:0] CTRL_HU = 3'b101;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  clr_idx_q, clr_idx_d;
    logic           misalign_err_q, misalign_err_d;
    logic [31:0]    mem_q [DEPTH_WORDS];

    logic [AW-1:0]  word_idx;
    logic [31:0]    rd_word;
    logic [7:0]     rd_byte;
    logic [15:0]    rd_half;
    logic           ctrl_legal;
    logic           misaligned;
    logic           store_ok;
    logic           mem_we;
    logic [AW-1:0]  mem_idx;
    logic [31:0]    mem_wdata;
    logic           unused_addr_hi;

    // Address bits above the array are ignored so accesses wrap.
    assign word_idx       = Address[AW+1:2];
    assign unused_addr_hi = ^Address[31:AW+2];
    assign rd_word        = mem_q[word_idx];

    // Decode of access size, legality and alignment
    always_comb begin
        ctrl_legal = 1'b0;
        misaligned = 1'b0;
        case (DMCtrl)
            CTRL_B, CTRL_BU: ctrl_legal = 1'b1;
            CTRL_H, CTRL_HU: begin
                ctrl_legal = 1'b1;
                misaligned = Address[0];
            end
            CTRL_W: begin
                ctrl_legal = 1'b1;
                misaligned = (Address[1:0] != 2'b00);
            end
            default: begin
                ctrl_legal = 1'b0;
                misaligned = 1'b0;
            end
        endcase
    end

    assign store_ok = DMWr && (state_q == RUN) && ctrl_legal && !misaligned;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= CLEAR;
            clr_idx_q      <= '0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            clr_idx_q      <= clr_idx_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        clr_idx_d      = clr_idx_q;
        misalign_err_d = misalign_err_q;
        case (state_q)
            CLEAR: begin
                clr_idx_d = clr_idx_q + AW'(1);
                if (clr_idx_q == AW'(DEPTH_WORDS - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (DMWr && ctrl_legal && misaligned) begin
                    misalign_err_d = 1'b1;
                end
            end
            default: state_d = CLEAR;
        endcase
    end

    // Output logic: load path and write-port control
    always_comb begin
        rd_byte = 8'h00;
        case (Address[1:0])
            2'd0: rd_byte = rd_word[7:0];
            2'd1: rd_byte = rd_word[15:8];
            2'd2: rd_byte = rd_word[23:16];
            2'd3: rd_byte = rd_word[31:24];
            default: rd_byte = 8'h00;
        endcase
        rd_half = Address[1] ? rd_word[31:16] : rd_word[15:0];

        DataRd = 32'h0;
        if ((state_q == RUN) && ctrl_legal && !misaligned) begin
            case (DMCtrl)
                CTRL_B:  DataRd = {{24{rd_byte[7]}}, rd_byte};
                CTRL_BU: DataRd = {24'h0, rd_byte};
                CTRL_H:  DataRd = {{16{rd_half[15]}}, rd_half};
                CTRL_HU: DataRd = {16'h0, rd_half};
                CTRL_W:  DataRd = rd_word;
                default: DataRd = 32'h0;
            endcase
        end

        // Store data merges the new lanes into the current word.
        mem_wdata = rd_word;
        case (DMCtrl)
            CTRL_B, CTRL_BU: begin
                case (Address[1:0])
                    2'd0: mem_wdata[7:0]   = DataWr[7:0];
                    2'd1: mem_wdata[15:8]  = DataWr[7:0];
                    2'd2: mem_wdata[23:16] = DataWr[7:0];
                    2'd3: mem_wdata[31:24] = DataWr[7:0];
                    default: mem_wdata = rd_word;
                endcase
            end
            CTRL_H, CTRL_HU: begin
                if (Address[1]) begin
                    mem_wdata[31:16] = DataWr[15:0];
                end else begin
                    mem_wdata[15:0] = DataWr[15:0];
                end
            end
            CTRL_W:  mem_wdata = DataWr;
            default: mem_wdata = rd_word;
        endcase

        mem_we  = 1'b0;
        mem_idx = word_idx;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_idx   = clr_idx_q;
                mem_wdata = 32'h0;
            end else if (store_ok) begin
                mem_we = 1'b1;
            end
        end

        Ready       = (state_q == RUN);
        MisalignErr = misalign_err_q;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_idx] <= mem_wdata;
        end
    end

endmodule

// File: doc/data_memory.md
DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, giving the number of 32-bit words; legal values are powers of two, 4 to 4096.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port Address, input, 32 bits: byte address from the ALU result.
REQ-005 The block SHALL have port DataWr, input, 32 bits: store data from register rs2.
REQ-006 The block SHALL have port DMWr, input, 1 bit: store request from the control unit.
REQ-007 The block SHALL have port DMCtrl, input, 3 bits: access size and sign, equal to the instruction funct3.
REQ-008 The block SHALL have port DataRd, output, 32 bits: load data, already extended.
REQ-009 The block SHALL have port Ready, output, 1 bit: high when the clear sweep is done and the memory accepts stores.
REQ-010 The block SHALL have port MisalignErr, output, 1 bit: sticky flag for a rejected misaligned store.

Function
REQ-011 Storage SHALL be DEPTH_WORDS little-endian 32-bit words, word index = Address[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-012 DMCtrl encodings SHALL be 000 B, 001 H, 010 W, 100 BU, 101 HU; codes 011, 110 and 111 are illegal: DataRd=0 and stores are suppressed with no error flag.
REQ-013 Alignment SHALL be: B/BU always aligned; H/HU misaligned when Address[0]=1; W misaligned when Address[1:0]!=00.
REQ-014 Reads SHALL be combinational from the current array contents: B/H sign-extended, BU/HU zero-extended.
REQ-015 Byte lane SHALL be Address[1:0]; halfword lane SHALL be Address[1].
REQ-016 DataRd SHALL be 0 for a misaligned access, for an illegal code, and whenever Ready=0.
REQ-017 A store SHALL commit on the rising edge when DMWr=1, Ready=1, the code is legal and the access is aligned.
REQ-018 A committed store SHALL modify only the addressed lanes: B writes DataWr[7:0], H writes DataWr[15:0], W writes all 32 bits.
REQ-019 A store SHALL be invisible on DataRd in its own cycle, visible from the next cycle (read-old-data).
REQ-020 A misaligned store with DMWr=1 and Ready=1 SHALL be suppressed and SHALL set MisalignErr at that edge.
REQ-021 MisalignErr SHALL stay 1 until rst.
REQ-022 Misaligned reads SHALL NOT set MisalignErr, because the address is presented on every cycle regardless of instruction type.
REQ-023 The state machine SHALL have two states, CLEAR and RUN, plus a clear index ClrIdx of log2(DEPTH_WORDS) bits.
REQ-024 In CLEAR, each edge SHALL write word[ClrIdx]=0 and increment ClrIdx.
REQ-025 The edge that clears word DEPTH_WORDS-1 SHALL move the machine to RUN; Ready = (state==RUN), registered.
REQ-026 Stores presented in CLEAR SHALL be dropped silently: no write, no error flag.
REQ-027 In RUN the machine SHALL stay in RUN until rst.

Reset
REQ-028 An edge with rst=1 SHALL force state=CLEAR, ClrIdx=0, Ready=0 and MisalignErr=0, overriding any store on that edge; DataRd reads 0 while Ready=0.
REQ-029 While rst is held the sweep SHALL NOT advance.
REQ-030 After rst falls, Ready SHALL rise exactly DEPTH_WORDS edges later, with every word equal to 0.
REQ-031 rst asserted mid-sweep or in RUN SHALL restart the sweep from index 0.

Verification
REQ-032 Bench SHALL cover reset and sweep: hold rst for 3 edges then release -> Ready=0 for exactly 256 edges, then 1; LW at 0x000 and 0x3FC returns 0x00000000.
REQ-033 Bench SHALL cover word store/load: SW 0xDEADBEEF at 0x10 -> next cycle LW 0x10=0xDEADBEEF, LBU 0x13=0x000000DE, LB 0x10=0xFFFFFFEF, LHU 0x12=0x0000DEAD, LH 0x10=0xFFFFBEEF.
REQ-034 Bench SHALL cover partial stores: SW 0x11223344 at 0x20, then SB DataWr=0xAA at 0x21, then SH DataWr=0x5566 at 0x22 -> LW 0x20=0x5566AA44.
REQ-035 Bench SHALL cover misalignment: SW at 0x22 with 0x12345678 -> word 0x20 unchanged and MisalignErr=1 next cycle, still 1 ten cycles later; LH at 0x21 returns 0; rst clears the flag.
REQ-036 Bench SHALL cover wrap and illegal code: SW 0xCAFEF00D at 0x400 -> LW 0x000=0xCAFEF00D; store with DMCtrl=011 -> no change, MisalignErr stays 0; store during CLEAR -> word reads 0 after Ready.
REQ-037 Bench SHALL cover reset mid-sweep: assert rst at sweep edge 100 for 1 edge -> Ready rises 256 edges after release.
